ysyx_24100005_dmem_responder: RTL and testbench
===============================================

// Module: ysyx_24100005_dmem_responder
// PURPOSE
// Data-memory responder: the slave end of the core's load/store port. Accepts one
// request at a time (valid/ready), waits a programmable latency, then returns
// read data or a write acknowledgement. Backs simulation and FPGA runs, replacing
// the DPI memory path with synthesizable word storage plus byte-mask writes.
// PARAMETERS
// ADDR_BASE   32'h8000_0000  byte address of word 0
// DEPTH_LOG2  10             log2 of storage depth in 32-bit words (1024 words = 4 KiB)
// LATENCY     2              cycles from request accept to rsp_valid; legal range 1..15
// PORTS
// clk        in   1   clock, all state updates on posedge
// rst        in   1   asynchronous reset, active-high
// req_valid  in   1   request present
// req_ready  out  1   responder can accept a request
// req_wen    in   1   1 = store, 0 = load
// req_addr   in   32  byte address; bits [1:0] ignored (word access)
// req_wdata  in   32  store data, already lane-aligned by the core
// req_wmask  in   8   byte enables; bits [3:0] used, bit n writes byte lane n; [7:4] ignored
// rsp_valid  out  1   response present
// rsp_ready  in   1   core accepts response
// rsp_rdata  out  32  load data (full word, core extracts/sign-extends lanes)
// rsp_err    out  1   address outside [ADDR_BASE, ADDR_BASE + 4*2^DEPTH_LOG2)
// BEHAVIOUR
// - Reset (async): state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   latched request cleared; req_ready=0 while rst high, 1 from the first cycle
//   after release. Storage contents are NOT reset.
// - FSM IDLE -> WAIT -> RESP -> IDLE. req_ready = (state==IDLE) && !rst.
// - IDLE: on posedge with req_valid && req_ready, latch wen/addr/wdata/wmask,
//   compute in-range flag, load counter with LATENCY-1, go WAIT (counter 0 -> straight to RESP).
// - WAIT: decrement counter each cycle; on the edge where counter==0 go RESP and:
//   read: rsp_rdata <= mem[index]; write: mem[index] bytes where wmask[n]=1 updated,
//   rsp_rdata <= 0. Out of range: no storage access, rsp_rdata <= 0, rsp_err <= 1.
//   Net latency: accept at edge T -> rsp_valid high after edge T+LATENCY.
// - RESP: rsp_valid=1; rsp_rdata/rsp_err stable until handshake. On rsp_valid &&
//   rsp_ready go IDLE, rsp_valid=0, rsp_err=0 (rsp_rdata holds last value).
//   rsp_ready low stalls indefinitely; no new request accepted meanwhile.
// - index = (req_addr - ADDR_BASE) >> 2, truncated to DEPTH_LOG2 bits after range check.
// - Write with wmask[3:0]==0: in-range, no bytes change, normal ack.
// - Read-after-write: write commits at the RESP-entry edge, so any later read
//   returns the new data; only one request is ever outstanding (no hazards).
// - Reset mid-operation: pending request dropped; a write not yet committed
//   (still in WAIT) never reaches storage; one already in RESP stays written.
// - req_* inputs are ignored outside IDLE; changes after accept have no effect.
// TESTING
// 1 Reset: rst=1 for 3 cycles mid-WAIT -> rsp_valid=0, rsp_err=0, req_ready=0 during
//   rst, 1 next cycle; pending store to 0x8000_0010 absent on later read.
// 2 Store/load: sw 0xDEADBEEF mask 4'hF @0x8000_0004, then lw same addr with
//   LATENCY=2 -> rsp_valid 2 cycles after each accept, rdata 0xDEADBEEF, err=0.
// 3 Byte mask: after (2), store 0x0000_5500 mask 4'b0010 -> read returns 0xDEAD55EF;
//   store 0x1234_0000 mask 4'b1100 -> read returns 0x123455EF.
// 4 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable,
//   req_ready=0, second req_valid not accepted until handshake completes.
// 5 Range: load 0x7FFF_FFFC and 0x8000_1000 (DEPTH_LOG2=10) -> rsp_err=1, rdata 0;
//   store to 0x8000_1000 leaves word 0 (0x8000_0000) unchanged.
// 6 Latency sweep: LATENCY=1 and 15, back-to-back requests with rsp_ready=1 ->
//   accept-to-rsp_valid exactly LATENCY cycles, one request per LATENCY+2 cycles.

Source files
------------

// File: rtl/ysyx_24100005_dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed LATENCY cycles from accept to response.
// Word storage with byte-lane writes; out-of-range accesses answer with rsp_err and zero data.
module ysyx_24100005_dmem_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    lat_wen;
  logic                    lat_in_range;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [31:0]             lat_wdata;
  logic [3:0]              lat_wmask;
  logic [31:0]             mem [DEPTH];

  logic [31:0]             offset;
  logic                    in_range;
  logic                    accept;
  logic                    commit;
  logic                    unused_mask_hi;

  assign unused_mask_hi = ^req_wmask[7:4];

  // Range test on the full offset; the index is only taken once the address is known to fit.
  assign offset   = req_addr - ADDR_BASE;
  assign in_range = (req_addr >= ADDR_BASE) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = !rst;
        accept    = req_valid && !rst;
        if (accept) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      lat_wen      <= 1'b0;
      lat_in_range <= 1'b0;
      lat_idx      <= '0;
      lat_wdata    <= 32'd0;
      lat_wmask    <= 4'd0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_wen      <= req_wen;
        lat_in_range <= in_range;
        lat_idx      <= offset[DEPTH_LOG2+1:2];
        lat_wdata    <= req_wdata;
        lat_wmask    <= req_wmask[3:0];
        cnt          <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        rsp_rdata <= (lat_in_range && !lat_wen) ? mem[lat_idx] : 32'd0;
        rsp_err   <= !lat_in_range;
      end else if (state == RESP && rsp_ready) begin
        rsp_err <= 1'b0;
      end
    end
  end

  // Storage is deliberately outside the reset domain; commit is already gated off while rst is high.
  always_ff @(posedge clk) begin
    if (commit && lat_wen && lat_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_wmask[b]) mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_dmem_responder.sv
// Directed bench for the data-memory responder: three instances cover LATENCY 2, 1 and 15.
module tb_ysyx_24100005_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_wen   [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [7:0]  req_wmask [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  ysyx_24100005_dmem_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  ysyx_24100005_dmem_responder #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  ysyx_24100005_dmem_responder #(.LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wen(req_wen[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  // Presents a request at a negedge and returns #1 after the accepting edge; fields are scrambled afterwards.
  task automatic send(input int d, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [7:0] mask, output int t_acc);
    int n = 0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr;
    req_wdata[d] = wdata; req_wmask[d] = mask;
    while (!req_ready[d] && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (req_ready[d] !== 1'b1) begin
      fails++;
      $display("FAIL accept_timeout dut%0d: req_ready=%b required 1", d, req_ready[d]);
    end
    @(posedge clk); #1;
    t_acc = cyc;
    req_valid[d] = 1'b0; req_wen[d] = ~wen; req_addr[d] = 32'h8000_0000;
    req_wdata[d] = ~wdata; req_wmask[d] = 8'hFF;
  endtask

  task automatic wait_rsp(input int d, output logic [31:0] rd, output logic er, output int lat);
    lat = 0;
    while (!rsp_valid[d] && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++;
    if (rsp_valid[d] !== 1'b1) begin
      fails++;
      $display("FAIL rsp_timeout dut%0d: rsp_valid=%b required 1", d, rsp_valid[d]);
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
  endtask

  task automatic xact(input int d, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [7:0] mask, output logic [31:0] rd, output logic er,
                      output int lat, output int t_acc);
    send(d, wen, addr, wdata, mask, t_acc);
    wait_rsp(d, rd, er, lat);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, t0, t1, t2;

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = 32'd0;
      req_wdata[d] = 32'd0; req_wmask[d] = 8'd0; rsp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk); #1;
    checks++;
    if (req_ready[0] !== 1'b0) begin fails++; $display("FAIL reset_req_ready: got %b required 0", req_ready[0]); end
    checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_err[0] !== 1'b0 || rsp_rdata[0] !== 32'd0) begin
      fails++; $display("FAIL reset_outputs: valid=%b err=%b rdata=%h required 0/0/0", rsp_valid[0], rsp_err[0], rsp_rdata[0]);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready[0] !== 1'b1 || req_ready[1] !== 1'b1 || req_ready[2] !== 1'b1) begin
      fails++; $display("FAIL release_req_ready: got %b%b%b required 111", req_ready[0], req_ready[1], req_ready[2]);
    end
    xact(0, 1'b1, 32'h8000_0010, 32'h1111_1111, 8'h0F, rd, er, lat, t0);
    // Store interrupted while still counting down must never land.
    send(0, 1'b1, 32'h8000_0010, 32'hA5A5_A5A5, 8'h0F, t0);
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
      fails++; $display("FAIL midwait_reset: valid=%b err=%b ready=%b required 0/0/0", rsp_valid[0], rsp_err[0], req_ready[0]);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      fails++; $display("FAIL after_midwait_reset: ready=%b valid=%b required 1/0", req_ready[0], rsp_valid[0]);
    end
    xact(0, 1'b0, 32'h8000_0010, 32'd0, 8'h00, rd, er, lat, t0);
    checks++;
    if (rd !== 32'h1111_1111) begin fails++; $display("FAIL dropped_store: got %h required 11111111", rd); end
  endtask

  task automatic test_store_load;
    xact(0, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 8'h0F, rd, er, lat, t0);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'd0) begin
      fails++; $display("FAIL store_ack: lat=%0d err=%b rdata=%h required 2/0/00000000", lat, er, rd);
    end
    xact(0, 1'b0, 32'h8000_0004, 32'd0, 8'h00, rd, er, lat, t0);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL load: lat=%0d err=%b rdata=%h required 2/0/deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_byte_mask;
    xact(0, 1'b1, 32'h8000_0004, 32'h0000_5500, 8'h02, rd, er, lat, t0);
    xact(0, 1'b0, 32'h8000_0006, 32'd0, 8'h00, rd, er, lat, t0);
    checks++;
    if (rd !== 32'hDEAD_55EF) begin fails++; $display("FAIL mask_lane1: got %h required dead55ef", rd); end
    xact(0, 1'b1, 32'h8000_0004, 32'h1234_0000, 8'h0C, rd, er, lat, t0);
    xact(0, 1'b0, 32'h8000_0004, 32'd0, 8'h00, rd, er, lat, t0);
    checks++;
    if (rd !== 32'h1234_55EF) begin fails++; $display("FAIL mask_lanes23: got %h required 123455ef", rd); end
    xact(0, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 8'hF0, rd, er, lat, t0);
    checks++;
    if (er !== 1'b0) begin fails++; $display("FAIL empty_mask_err: got %b required 0", er); end
    xact(0, 1'b0, 32'h8000_0004, 32'd0, 8'h00, rd, er, lat, t0);
    checks++;
    if (rd !== 32'h1234_55EF) begin fails++; $display("FAIL empty_mask_data: got %h required 123455ef", rd); end
  endtask

  task automatic test_backpressure;
    rsp_ready[0] = 1'b0;
    send(0, 1'b0, 32'h8000_0004, 32'd0, 8'h00, t0);
    wait_rsp(0, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 32'h1234_55EF) begin
      fails++; $display("FAIL bp_first: lat=%0d rdata=%h required 2/123455ef", lat, rd);
    end
    @(negedge clk);
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 32'h8000_0010; req_wmask[0] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h1234_55EF || req_ready[0] !== 1'b0) begin
        fails++; $display("FAIL bp_stall%0d: valid=%b rdata=%h ready=%b required 1/123455ef/0", i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
      end
    end
    @(negedge clk); rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      fails++; $display("FAIL bp_handshake: valid=%b ready=%b required 0/1", rsp_valid[0], req_ready[0]);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(0, rd, er, lat);
    checks++;
    if (lat !== 2 || rd !== 32'h1111_1111) begin
      fails++; $display("FAIL bp_second: lat=%0d rdata=%h required 2/11111111", lat, rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_range;
    xact(0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 8'h0F, rd, er, lat, t0);
    xact(0, 1'b1, 32'h8000_0FFC, 32'h0BAD_C0DE, 8'h0F, rd, er, lat, t0);
    xact(0, 1'b0, 32'h8000_0FFC, 32'd0, 8'h00, rd, er, lat, t0);
    checks++;
    if (rd !== 32'h0BAD_C0DE || er !== 1'b0) begin
      fails++; $display("FAIL last_word: rdata=%h err=%b required 0badc0de/0", rd, er);
    end
    xact(0, 1'b0, 32'h7FFF_FFFC, 32'd0, 8'h00, rd, er, lat, t0);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      fails++; $display("FAIL below_base: rdata=%h err=%b required 00000000/1", rd, er);
    end
    checks++;
    if (rsp_err[0] !== 1'b0) begin fails++; $display("FAIL err_clear: got %b required 0", rsp_err[0]); end
    xact(0, 1'b0, 32'h8000_1000, 32'd0, 8'h00, rd, er, lat, t0);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin
      fails++; $display("FAIL above_top: rdata=%h err=%b required 00000000/1", rd, er);
    end
    xact(0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 8'h0F, rd, er, lat, t0);
    checks++;
    if (er !== 1'b1) begin fails++; $display("FAIL oor_store_err: got %b required 1", er); end
    xact(0, 1'b0, 32'h8000_0000, 32'd0, 8'h00, rd, er, lat, t0);
    checks++;
    if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin
      fails++; $display("FAIL word0_intact: rdata=%h err=%b required cafef00d/0", rd, er);
    end
  endtask

  task automatic test_back_to_back(input int d, input int l);
    logic [31:0] wv;
    wv = 32'h5A5A_0000 | 32'(l);
    xact(d, 1'b1, 32'h8000_0008, wv, 8'h0F, rd, er, lat, t0);
    checks++;
    if (lat !== l) begin fails++; $display("FAIL lat%0d_store: got %0d required %0d", l, lat, l); end
    xact(d, 1'b0, 32'h8000_0008, 32'd0, 8'h00, rd, er, lat, t1);
    checks++;
    if (lat !== l || rd !== wv) begin
      fails++; $display("FAIL lat%0d_load: lat=%0d rdata=%h required %0d/%h", l, lat, rd, l, wv);
    end
    xact(d, 1'b0, 32'h8000_0008, 32'd0, 8'h00, rd, er, lat, t2);
    checks++;
    if ((t1 - t0) !== l + 2 || (t2 - t1) !== l + 2) begin
      fails++; $display("FAIL lat%0d_spacing: got %0d,%0d required %0d", l, t1 - t0, t2 - t1, l + 2);
    end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_byte_mask;
    test_backpressure;
    test_range;
    test_back_to_back(1, 1);
    test_back_to_back(2, 15);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
